// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO management controller.
package mdio_pkg;

  typedef enum logic [1:0] {
    READ  = 2'b10,
    WRITE = 2'b01
  } mdio_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } mdio_state_e;

  localparam logic [1:0]  MDIO_ST      = 2'b01;
  localparam logic [1:0]  MDIO_TA_WR   = 2'b10;
  localparam int unsigned MDIO_PRE_LEN = 32;

  typedef struct packed {
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mdio_cmd_t;

  // Read frames carry ones in TA/DATA; those bits are never driven (oe=0).
  function automatic logic [63:0] mdio_frame(input mdio_cmd_t cmd);
    mdio_op_e op;
    op = cmd.write ? WRITE : READ;
    return {{MDIO_PRE_LEN{1'b1}}, MDIO_ST, op, cmd.phy, cmd.regad,
            (cmd.write ? MDIO_TA_WR : 2'b11),
            (cmd.write ? cmd.wdata : 16'hFFFF)};
  endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Command/response and MDIO pin bundle between the controller and its environment.
interface mdio_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i;

  modport master (
    input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, mdio_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdc, mdio_o, mdio_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, mdio_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdc, mdio_o, mdio_oe
  );
endinterface

// File: rtl/mdio_clk_gen.sv
// MDC divider: CLK_DIV clk cycles per half-period, parked low while disabled.
// o_fall_stb marks the last high cycle, o_rise_stb the first high cycle.
module mdio_clk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_mdc,
  output logic o_fall_stb,
  output logic o_rise_stb
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_mdc;

  // Half-period counter and MDC toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CW{1'b0}};
      r_mdc <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= {CW{1'b0}};
      r_mdc <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= {CW{1'b0}};
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_mdc      = r_mdc;
  assign o_fall_stb = i_en && r_mdc && (r_cnt == CNT_MAX);
  assign o_rise_stb = i_en && r_mdc && (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one read/write frame per accepted command.
// Optional MDIO_PREAMBLE_SUPPRESS_EN drops the 32-bit preamble (32-bit frames).
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input logic           clk,
  input logic           rst,
  mdio_master_if.master bus
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int FRAME_LEN = 64 - MDIO_PRE_LEN;
`else
  localparam int FRAME_LEN = 64;
`endif
  localparam logic [5:0] LAST_BIT = 6'(FRAME_LEN - 1);
  localparam logic [5:0] OE_LEN   = 6'(FRAME_LEN - 18);
  localparam logic [5:0] TA2_BIT  = 6'(FRAME_LEN - 17);
  localparam logic [5:0] DATA_BIT = 6'(FRAME_LEN - 16);

  mdio_state_e r_state, w_state_nxt;
  logic        r_write;
  logic [63:0] r_shift;
  logic [5:0]  r_bit;
  logic        r_mdio_o;
  logic        r_mdio_oe;
  logic [15:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_en;
  logic        w_mdc;
  logic        w_fall_stb;
  logic        w_rise_stb;
  logic [5:0]  w_bit_nxt;
  mdio_cmd_t   w_cmd;
  logic [63:0] w_frame;
  logic [63:0] w_frame_al;

  assign w_accept  = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_en      = (r_state == ST_SHIFT);
  assign w_bit_nxt = r_bit + 6'd1;
  assign w_cmd     = '{write: bus.cmd_write, phy: bus.cmd_phy_addr,
                       regad: bus.cmd_reg_addr, wdata: bus.cmd_wdata};
  assign w_frame   = mdio_frame(w_cmd);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign w_frame_al = {w_frame[31:0], 32'hFFFF_FFFF};
`else
  assign w_frame_al = w_frame;
`endif

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_en),
    .o_mdc      (w_mdc),
    .o_fall_stb (w_fall_stb),
    .o_rise_stb (w_rise_stb)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.cmd_valid) w_state_nxt = ST_SHIFT;
                else               w_state_nxt = ST_IDLE;
      ST_SHIFT: if (w_fall_stb && (r_bit == LAST_BIT)) w_state_nxt = ST_DONE;
                else                                   w_state_nxt = ST_SHIFT;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame shifter, pin drivers and read capture; the new bit is launched on the MDC fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write   <= 1'b0;
      r_shift   <= {64{1'b1}};
      r_bit     <= 6'd0;
      r_mdio_o  <= 1'b1;
      r_mdio_oe <= 1'b0;
      r_rdata   <= 16'h0000;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_write   <= bus.cmd_write;
      r_mdio_o  <= w_frame_al[63];
      r_shift   <= {w_frame_al[62:0], 1'b1};
      r_mdio_oe <= 1'b1;
      r_bit     <= 6'd0;
      r_rdata   <= 16'h0000;
      r_err     <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      if (w_fall_stb) begin
        if (r_bit == LAST_BIT) begin
          r_mdio_o  <= 1'b1;
          r_mdio_oe <= 1'b0;
        end else begin
          r_bit     <= w_bit_nxt;
          r_mdio_o  <= r_shift[63];
          r_shift   <= {r_shift[62:0], 1'b1};
          r_mdio_oe <= r_write || (w_bit_nxt < OE_LEN);
        end
      end
      if (w_rise_stb && !r_write) begin
        if (r_bit == TA2_BIT)  r_err   <= bus.mdio_i;
        if (r_bit >= DATA_BIT) r_rdata <= {r_rdata[14:0], bus.mdio_i};
      end
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.mdc       = w_mdc;
  assign bus.mdio_o    = r_mdio_o;
  assign bus.mdio_oe   = r_mdio_oe;

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master at CLK_DIV=4 with a simple PHY model on the pin.
module tb_mdio_master;

  localparam int D = 4;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int N = 32;
  localparam logic [63:0] MASK = 64'h0000_0000_FFFF_FFFF;
`else
  localparam int N = 64;
  localparam logic [63:0] MASK = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  mdio_master_if bus();

  mdio_master #(.CLK_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  int          acc_edge = 0;
  int          gap      = 0;
  int          n_acc    = 0;
  int          n_rsp    = 0;
  int          bitidx   = 0;
  logic [63:0] cap_o    = '0;
  logic [63:0] cap_oe   = '0;
  logic [63:0] snap_o   = '0;
  logic [63:0] snap_oe  = '0;
  logic        prev_mdc = 1'b0;

  logic        phy_en   = 1'b0;
  logic        phy_oe   = 1'b0;
  logic        phy_d    = 1'b1;
  logic [15:0] phy_data = 16'h0000;

  assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : (phy_oe ? phy_d : 1'b1);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wr_frame(input logic [4:0] pa, input logic [4:0] ra,
                                           input logic [15:0] d);
    return {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, d};
  endfunction

  // Monitor: bit capture on MDC rise, accept bookkeeping, scoreboard pop on response
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.mdc && !prev_mdc) begin
        cap_o  = {cap_o[62:0], bus.mdio_o};
        cap_oe = {cap_oe[62:0], bus.mdio_oe};
        bitidx++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        gap      = cyc - acc_edge + 1;
        acc_edge = cyc + 1;
        cap_o    = '0;
        cap_oe   = '0;
        bitidx   = 0;
        n_acc++;
      end
      if (bus.rsp_valid) begin
        exp_t e;
        n_rsp++;
        snap_o  = cap_o;
        snap_oe = cap_oe;
        check("rsp_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          check("rsp_cycle", 64'(cyc - acc_edge + 1), 64'(1 + 2 * D * N));
        end
      end
    end
    prev_mdc = bus.mdc;
  end

  // PHY model: launches TA/DATA on MDC falling edges
  initial forever begin
    int k;
    @(negedge bus.mdc);
    k = bitidx;
    if (phy_en && k == N - 17) begin
      phy_oe = 1'b1;
      phy_d  = 1'b0;
    end else if (phy_en && k >= N - 16 && k < N) begin
      phy_oe = 1'b1;
      phy_d  = phy_data[N - 1 - k];
    end else begin
      phy_oe = 1'b0;
    end
  end

  task automatic set_cmd(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd);
    bus.cmd_write    = w;
    bus.cmd_phy_addr = pa;
    bus.cmd_reg_addr = ra;
    bus.cmd_wdata    = wd;
  endtask

  task automatic wait_accept(input int n0);
    int t = 0;
    while (n_acc == n0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_seen", 64'(n_acc != n0), 64'd1);
  endtask

  task automatic send(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                      input logic [15:0] wd, input logic [15:0] er, input logic ee);
    int n0 = n_acc;
    sb.push_back('{rdata: er, err: ee});
    set_cmd(w, pa, ra, wd);
    bus.cmd_valid = 1'b1;
    wait_accept(n0);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    check("rsp_pending", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] hdr;
    int          t;
    int          n0;
    int          r0;
    bus.cmd_valid = 1'b0;
    set_cmd(1'b0, 5'd0, 5'd0, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_err", 64'(bus.rsp_err), 64'd0);
    check("rst_mdc", 64'(bus.mdc), 64'd0);
    check("rst_mdio_o", 64'(bus.mdio_o), 64'd1);
    check("rst_mdio_oe", 64'(bus.mdio_oe), 64'd0);

    // Write PHY 1 reg 0 data 0x1140
    send(1'b1, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0);
    @(posedge clk); #1;
    check("wr_busy", 64'(bus.busy), 64'd1);
    wait_done();
    check("wr_stream", snap_o & MASK, 64'hFFFF_FFFF_5082_1140 & MASK);
    check("wr_oe", snap_oe & MASK, MASK);

    // Read PHY 3 reg 2 with PHY returning 0x0022
    phy_en   = 1'b1;
    phy_data = 16'h0022;
    send(1'b0, 5'd3, 5'd2, 16'hDEAD, 16'h0022, 1'b0);
    wait_done();
    hdr = {18'h0, 32'hFFFF_FFFF, 2'b01, 2'b10, 5'd3, 5'd2};
    check("rd_oe", snap_oe & MASK, 64'hFFFF_FFFF_FFFC_0000 & MASK);
    check("rd_header", (snap_o & MASK) >> 18, hdr & (MASK >> 18));
    repeat (5) @(posedge clk); #1;
    check("rd_hold", 64'(bus.rsp_rdata), 64'h0022);

    // Read with no PHY: pulled-up pin
    phy_en = 1'b0;
    send(1'b0, 5'd4, 5'd17, 16'h0000, 16'hFFFF, 1'b1);
    wait_done();

    // Back-to-back with cmd_valid held high and fields toggled mid-frame
    phy_en   = 1'b1;
    phy_data = 16'h8001;
    sb.push_back('{rdata: 16'h0000, err: 1'b0});
    sb.push_back('{rdata: 16'h8001, err: 1'b0});
    n0 = n_acc;
    set_cmd(1'b1, 5'd5, 5'd9, 16'hA5C3);
    bus.cmd_valid = 1'b1;
    wait_accept(n0);
    t = 0;
    while (t < 4000) begin
      @(posedge clk); #1;
      if (sb.size() != 2) break;
      set_cmd(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
      t++;
    end
    check("b2b_a_stream", snap_o & MASK, wr_frame(5'd5, 5'd9, 16'hA5C3) & MASK);
    check("b2b_a_oe", snap_oe & MASK, MASK);
    set_cmd(1'b0, 5'd7, 5'd1, 16'h0000);
    n0 = n_acc;
    wait_accept(n0);
    bus.cmd_valid = 1'b0;
    check("b2b_accept_cycle", 64'(gap), 64'(2 + 2 * D * N));
    wait_done();
    phy_en = 1'b0;

    // Reset during the high half of bit 40 (PHYAD LSB of a PHY-0 write drives 0)
    send(1'b1, 5'd0, 5'd6, 16'h1234, 16'h0000, 1'b0);
    t = 0;
    while (bitidx != 41 && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    check("rst_bit_reached", 64'(bitidx), 64'd41);
    r0 = n_rsp;
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_mdc", 64'(bus.mdc), 64'd0);
    check("mid_rst_mdio_oe", 64'(bus.mdio_oe), 64'd0);
    check("mid_rst_mdio_o", 64'(bus.mdio_o), 64'd1);
    check("mid_rst_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    check("no_rsp_after_rst", 64'(n_rsp - r0), 64'd0);

    send(1'b1, 5'd2, 5'd4, 16'hBEEF, 16'h0000, 1'b0);
    wait_done();
    check("post_rst_stream", snap_o & MASK, wr_frame(5'd2, 5'd4, 16'hBEEF) & MASK);
    check("post_rst_oe", snap_oe & MASK, MASK);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO management controller that configures and monitors the Ethernet PHY sitting on the MII datapath. It accepts one register read or write command at a time, serialises it as a standard MDIO frame on MDC/MDIO, and returns read data or completion status. It sits beside the MAC. The PHY's MDIO pin is bidirectional, so the top level builds the tri-state buffer from `mdio_o`/`mdio_oe`/`mdio_i`.

## Interface
- `CLK_DIV`, default 50: `clk` cycles per MDC half-period. Minimum 2.
- `clk`, input, 1: sole clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `cmd_valid`, input, 1: command request.
- `cmd_ready`, output, 1: controller idle, so a command is accepted when valid && ready.
- `cmd_write`, input, 1: 1 = write, 0 = read.
- `cmd_phy_addr`, input, 5: PHYAD.
- `cmd_reg_addr`, input, 5: REGAD.
- `cmd_wdata`, input, 16: write data.
- `rsp_valid`, output, 1: one-cycle completion pulse.
- `rsp_rdata`, output, 16: read data, 0 for writes.
- `rsp_err`, output, 1: read turnaround error.
- `busy`, output, 1: frame in progress.
- `mdc`, output, 1: management clock.
- `mdio_o`, output, 1: MDIO drive value.
- `mdio_oe`, output, 1: MDIO drive enable.
- `mdio_i`, input, 1: MDIO pin sample.

## Operation
- States:
  - IDLE → SHIFT on accept. All command fields are latched at accept.
  - SHIFT → DONE after the last frame bit.
  - DONE → IDLE after one cycle.
- Frame is 64 bits, MSB first:
  - PRE: 32 ones.
  - ST: `01`.
  - OP: `10` for read, `01` for write.
  - PHYAD: 5 bits.
  - REGAD: 5 bits.
  - TA: 2 bits.
  - DATA: 16 bits.
- Write: TA = `10` driven; `mdio_oe`=1 for all 64 bits.
- Read: `mdio_oe`=1 through REGAD, then 0 for TA and DATA.
  - Second TA bit is sampled; if it is 1, `rsp_err`=1.
  - DATA bits are shifted into `rsp_rdata` regardless of error, so no PHY yields 0xFFFF.
- `cmd_ready` = (state == IDLE). `busy` = !`cmd_ready`. Inputs are ignored while busy.
- `rsp_valid` is asserted only in DONE. `rsp_rdata`/`rsp_err` hold until the next accept.
- Reset mid-frame takes effect immediately (asynchronous):
  - FSM goes to IDLE, the frame is aborted and no `rsp_valid` is issued.
  - Outputs take their reset values.
- Reset values: `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mdc`=0, `mdio_o`=1, `mdio_oe`=0.
- In IDLE: `mdc`=0, `mdio_oe`=0, `mdio_o`=1.

## Timing
- Let D = `CLK_DIV`, accept at cycle 0.
- Bit i (0-based) occupies cycles 1+2D·i … 2D·(i+1).
  - `mdc`=0 for the first D cycles, 1 for the last D.
  - `mdio_o`/`mdio_oe` are updated registered at the bit's first cycle, i.e. at the MDC falling edge or frame start.
  - Read sampling of `mdio_i` happens at the first cycle of the bit's high half.
- `rsp_valid` is high at cycle 1+2D·N, where N = frame bits (64).
- `cmd_ready` is high again at cycle 2+2D·N. Minimum command spacing is 2+2D·N cycles.
- MDC divider counter width is $clog2(D); it wraps from D−1 to 0 and toggles `mdc`.
- Bit counter is 6 bits and terminates at N−1; there is no wrap.

## Configuration
- `MDIO_PREAMBLE_SUPPRESS_EN` defined:
  - PRE is omitted, N = 32, and the frame starts at ST.
  - Only for PHYs supporting preamble suppression.
- Undefined: full 32-bit preamble, N = 64.

## Structure
- `mdio_pkg` holds:
  - `mdio_op_e` (READ=2'b10, WRITE=2'b01).
  - `MDIO_ST`=2'b01, `MDIO_TA_WR`=2'b10.
  - `MDIO_PRE_LEN`=32.
  - FSM state enum.
  - `mdio_cmd_t` packed struct (write, phy, reg, wdata).
- Sub-module `mdio_clk_gen`: D-divider producing `mdc`, plus one-cycle `fall_stb`/`rise_stb`. Enabled only in SHIFT and cleared to the low phase on enable.

## Test plan
- D=4, write PHY 1 reg 0 data 0x1140:
  - `mdio_o` bit stream is 32×1, `0101`, `00001`, `00000`, `10`, `0001000101000000`, with `mdio_oe`=1 throughout.
  - `rsp_valid` at cycle 513; `rsp_rdata`=0.
- D=4, read PHY 3 reg 2, PHY model drives TA=Z/0 and data 0x0022 on MDC falling edges:
  - `mdio_oe` drops after bit 45.
  - `rsp_rdata`=0x0022, `rsp_err`=0.
- Read with `mdio_i` pulled high (no PHY) → `rsp_rdata`=0xFFFF, `rsp_err`=1.
- `cmd_valid` held high continuously with two queued commands:
  - Second is accepted exactly at cycle 514.
  - No field changes are observed mid-frame when inputs are toggled.
- Assert `rst` during bit 40 →
  - Same cycle: `mdc`=0, `mdio_oe`=0, `mdio_o`=1, `cmd_ready`=1.
  - No `rsp_valid`.
  - Next command produces a complete frame.
- `MDIO_PREAMBLE_SUPPRESS_EN` defined, D=4, write → first driven bits are `01`, `rsp_valid` at cycle 257.
